// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate on issue, capture on writeback, retire the head in order.
// Optional same-cycle writeback bypass on the query ports: define ROB_WB_BYPASS_EN.
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [1:0]                issue_type,
  input  logic [4:0]                issue_dest,
  input  logic                      issue_pred_taken,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [4:0]                issue_rd,
  input  logic                      wb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]               wb_value,
  input  logic                      wb_taken,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
  output logic [31:0]               get_value1,
  output logic [31:0]               get_value2,
  output logic                      get_ready1,
  output logic                      get_ready2,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic                      commit_store,
  output logic                      flush,
  output logic [31:0]               flush_pc
);
  localparam int DEPTH = 1 << ROB_SIZE_WIDTH;

  logic [ROB_SIZE_WIDTH-1:0] r_head;
  logic [ROB_SIZE_WIDTH-1:0] r_tail;
  logic [ROB_SIZE_WIDTH:0]   r_count;
  logic [DEPTH-1:0]          r_busy;
  logic [DEPTH-1:0]          r_ready;
  logic [1:0]                r_type  [DEPTH];
  logic [4:0]                r_dest  [DEPTH];
  logic                      r_pred  [DEPTH];
  logic                      r_taken [DEPTH];
  logic [31:0]               r_value [DEPTH];

  logic                      w_issue;
  logic                      w_commit;
  logic                      w_mispredict;
  logic                      w_wb;
  logic [ROB_SIZE_WIDTH:0]   w_count_next;
  logic [DEPTH-1:0]          w_issue_sel;
  logic [DEPTH-1:0]          w_commit_sel;
  logic [DEPTH-1:0]          w_wb_sel;

  assign w_issue      = rdy & issue_valid & ~rob_full & ~flush;
  assign w_commit     = rdy & r_busy[r_head] & r_ready[r_head];
  assign w_mispredict = w_commit & (r_type[r_head] == 2'd2) & (r_taken[r_head] != r_pred[r_head]);
  assign w_wb         = rdy & wb_valid & r_busy[wb_rob_id] & ~w_mispredict;

  assign issue_rob_id = r_tail;
  assign issue_rd     = (w_issue && (issue_type == 2'd0 || issue_type == 2'd3)) ? issue_dest : 5'd0;

  always_comb begin
    w_count_next = r_count;
    if (w_issue && !w_commit)
      w_count_next = r_count + 1'b1;
    else if (!w_issue && w_commit)
      w_count_next = r_count - 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign w_issue_sel[gi]  = w_issue  && (r_tail    == ROB_SIZE_WIDTH'(gi));
      assign w_commit_sel[gi] = w_commit && (r_head    == ROB_SIZE_WIDTH'(gi));
      assign w_wb_sel[gi]     = w_wb     && (wb_rob_id == ROB_SIZE_WIDTH'(gi));
    end
  endgenerate

  // Per-entry status bits; a mispredict wipes every entry on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_ready <= '0;
    end else if (w_mispredict) begin
      r_busy  <= '0;
      r_ready <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue_sel[i]) begin
          r_busy[i]  <= 1'b1;
          r_ready[i] <= 1'b0;
        end else begin
          if (w_commit_sel[i]) r_busy[i]  <= 1'b0;
          if (w_wb_sel[i])     r_ready[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_type[r_tail] <= (issue_type == 2'd3) ? 2'd0 : issue_type;
      r_dest[r_tail] <= issue_dest;
      r_pred[r_tail] <= issue_pred_taken;
    end
    if (w_wb) begin
      r_value[wb_rob_id] <= wb_value;
      r_taken[wb_rob_id] <= wb_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      rob_full      <= 1'b0;
      commit_rd     <= 5'd0;
      commit_value  <= 32'd0;
      commit_rob_id <= '0;
      commit_store  <= 1'b0;
      flush         <= 1'b0;
      flush_pc      <= 32'd0;
    end else if (rdy) begin
      commit_rd    <= 5'd0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      if (w_commit) begin
        commit_value  <= r_value[r_head];
        commit_rob_id <= r_head;
        case (r_type[r_head])
          2'd1:    commit_store <= 1'b1;
          2'd2: begin
            if (w_mispredict) begin
              flush    <= 1'b1;
              flush_pc <= r_value[r_head];
            end
          end
          default: commit_rd <= r_dest[r_head];
        endcase
      end
      if (w_mispredict) begin
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        rob_full <= 1'b0;
      end else begin
        if (w_issue)  r_tail <= r_tail + 1'b1;
        if (w_commit) r_head <= r_head + 1'b1;
        r_count  <= w_count_next;
        rob_full <= (w_count_next == (ROB_SIZE_WIDTH+1)'(DEPTH));
      end
    end
  end

  always_comb begin
    get_ready1 = r_busy[ask_rob_id1] & r_ready[ask_rob_id1];
    get_value1 = r_value[ask_rob_id1];
    get_ready2 = r_busy[ask_rob_id2] & r_ready[ask_rob_id2];
    get_value2 = r_value[ask_rob_id2];
`ifdef ROB_WB_BYPASS_EN
    if (wb_valid && wb_rob_id == ask_rob_id1 && r_busy[ask_rob_id1]) begin
      get_ready1 = 1'b1;
      get_value1 = wb_value;
    end
    if (wb_valid && wb_rob_id == ask_rob_id2 && r_busy[ask_rob_id2]) begin
      get_ready2 = 1'b1;
      get_value2 = wb_value;
    end
`endif
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue, writeback, in-order commit, full, flush, store, query, stall.
module tb_reorder_buffer;
  logic        clk = 0;
  logic        rst, rdy;
  logic        issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_dest;
  logic        rob_full;
  logic [2:0]  issue_rob_id;
  logic [4:0]  issue_rd;
  logic        wb_valid, wb_taken;
  logic [2:0]  wb_rob_id, ask_rob_id1, ask_rob_id2;
  logic [31:0] wb_value, get_value1, get_value2;
  logic        get_ready1, get_ready2;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;
  logic [2:0]  commit_rob_id;
  logic        commit_store, flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_SIZE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_dest(issue_dest),
    .issue_pred_taken(issue_pred_taken), .rob_full(rob_full), .issue_rob_id(issue_rob_id),
    .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .wb_taken(wb_taken), .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
    .get_value1(get_value1), .get_value2(get_value2), .get_ready1(get_ready1),
    .get_ready2(get_ready2), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id), .commit_store(commit_store), .flush(flush),
    .flush_pc(flush_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; issue_valid = 0; issue_type = 0; issue_dest = 0; issue_pred_taken = 0;
    wb_valid = 0; wb_rob_id = 0; wb_value = 0; wb_taken = 0; ask_rob_id1 = 0; ask_rob_id2 = 0;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] d, input logic p);
    issue_valid = 1; issue_type = t; issue_dest = d; issue_pred_taken = p;
    step();
    issue_valid = 0;
  endtask

  task automatic wback(input logic [2:0] id, input logic [31:0] v, input logic tk);
    wb_valid = 1; wb_rob_id = id; wb_value = v; wb_taken = tk;
    step();
    wb_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", rob_full); end
    n_tests++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL reset_commit_rd got %0d exp 0", commit_rd); end
    n_tests++; if (commit_store !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got store=%0b flush=%0b exp 0 0", commit_store, flush); end
    n_tests++; if (flush_pc !== 32'd0 || commit_value !== 32'd0) begin n_fail++; $display("FAIL reset_values got pc=%h val=%h exp 0 0", flush_pc, commit_value); end
    n_tests++; if (issue_rob_id !== 3'd0 || get_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_tail got id=%0d rdy1=%0b exp 0 0", issue_rob_id, get_ready1); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    issue_valid = 1; issue_type = 0; issue_dest = 5;
    #1;
    n_tests++; if (issue_rob_id !== 3'd0 || issue_rd !== 5'd5) begin n_fail++; $display("FAIL basic_issue got id=%0d rd=%0d exp 0 5", issue_rob_id, issue_rd); end
    step(); issue_valid = 0;
    wback(3'd0, 32'h1234, 1'b0);
    n_tests++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL basic_early got rd=%0d exp 0", commit_rd); end
    step();
    n_tests++; if (commit_rd !== 5'd5 || commit_value !== 32'h1234 || commit_rob_id !== 3'd0) begin n_fail++; $display("FAIL basic_commit got rd=%0d val=%h id=%0d exp 5 1234 0", commit_rd, commit_value, commit_rob_id); end
    step();
    n_tests++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL basic_pulse got rd=%0d exp 0", commit_rd); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (issue_rob_id !== 3'(i)) begin n_fail++; $display("FAIL full_id%0d got %0d exp %0d", i, issue_rob_id, i); end
      issue(2'd0, 5'(i + 1), 1'b0);
    end
    n_tests++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %0b exp 1", rob_full); end
    issue_valid = 1; issue_type = 0; issue_dest = 9;
    #1;
    n_tests++; if (issue_rd !== 5'd0) begin n_fail++; $display("FAIL full_reject_rd got %0d exp 0", issue_rd); end
    step(); issue_valid = 0;
    n_tests++; if (issue_rob_id !== 3'd0 || rob_full !== 1'b1) begin n_fail++; $display("FAIL full_hold got id=%0d full=%0b exp 0 1", issue_rob_id, rob_full); end
    wback(3'd0, 32'hA, 1'b0);
    step();
    n_tests++; if (commit_rd !== 5'd1 || rob_full !== 1'b0 || issue_rob_id !== 3'd0) begin n_fail++; $display("FAIL full_release got rd=%0d full=%0b id=%0d exp 1 0 0", commit_rd, rob_full, issue_rob_id); end
    $display("[TB] test_full done");
  endtask

  task automatic test_out_of_order();
    do_reset();
    issue(2'd0, 5'd10, 1'b0);
    issue(2'd0, 5'd11, 1'b0);
    issue(2'd0, 5'd12, 1'b0);
    wback(3'd2, 32'h22, 1'b0);
    wback(3'd1, 32'h11, 1'b0);
    n_tests++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL ooo_none got rd=%0d exp 0", commit_rd); end
    wback(3'd0, 32'h00, 1'b0);
    step();
    n_tests++; if (commit_rd !== 5'd10 || commit_rob_id !== 3'd0) begin n_fail++; $display("FAIL ooo_c0 got rd=%0d id=%0d exp 10 0", commit_rd, commit_rob_id); end
    step();
    n_tests++; if (commit_rd !== 5'd11 || commit_rob_id !== 3'd1 || commit_value !== 32'h11) begin n_fail++; $display("FAIL ooo_c1 got rd=%0d id=%0d val=%h exp 11 1 11", commit_rd, commit_rob_id, commit_value); end
    step();
    n_tests++; if (commit_rd !== 5'd12 || commit_rob_id !== 3'd2 || commit_value !== 32'h22) begin n_fail++; $display("FAIL ooo_c2 got rd=%0d id=%0d val=%h exp 12 2 22", commit_rd, commit_rob_id, commit_value); end
    step();
    n_tests++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL ooo_end got rd=%0d exp 0", commit_rd); end
    $display("[TB] test_out_of_order done");
  endtask

  task automatic test_flush();
    do_reset();
    issue(2'd2, 5'd0, 1'b0);
    issue(2'd0, 5'd7, 1'b0);
    issue(2'd0, 5'd8, 1'b0);
    wback(3'd1, 32'h5, 1'b0);
    wback(3'd0, 32'h80, 1'b1);
    step();
    n_tests++; if (flush !== 1'b1 || flush_pc !== 32'h80) begin n_fail++; $display("FAIL flush_pulse got flush=%0b pc=%h exp 1 80", flush, flush_pc); end
    n_tests++; if (commit_rd !== 5'd0 || commit_store !== 1'b0) begin n_fail++; $display("FAIL flush_no_write got rd=%0d st=%0b exp 0 0", commit_rd, commit_store); end
    issue_valid = 1; issue_type = 0; issue_dest = 9; ask_rob_id1 = 3'd1;
    #1;
    n_tests++; if (issue_rd !== 5'd0 || get_ready1 !== 1'b0) begin n_fail++; $display("FAIL flush_block got rd=%0d rdy1=%0b exp 0 0", issue_rd, get_ready1); end
    step(); issue_valid = 0;
    n_tests++; if (flush !== 1'b0 || issue_rob_id !== 3'd0) begin n_fail++; $display("FAIL flush_after got flush=%0b id=%0d exp 0 0", flush, issue_rob_id); end
    step();
    n_tests++; if (commit_rd !== 5'd0 || rob_full !== 1'b0) begin n_fail++; $display("FAIL flush_empty got rd=%0d full=%0b exp 0 0", commit_rd, rob_full); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_store();
    do_reset();
    issue(2'd1, 5'd9, 1'b0);
    wback(3'd0, 32'h0, 1'b0);
    step();
    n_tests++; if (commit_store !== 1'b1 || commit_rd !== 5'd0) begin n_fail++; $display("FAIL store_commit got st=%0b rd=%0d exp 1 0", commit_store, commit_rd); end
    step();
    n_tests++; if (commit_store !== 1'b0) begin n_fail++; $display("FAIL store_pulse got %0b exp 0", commit_store); end
    $display("[TB] test_store done");
  endtask

  task automatic test_query_stall();
    logic exp_now;
    do_reset();
    for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 1'b0);
    ask_rob_id1 = 3'd3;
    wb_valid = 1; wb_rob_id = 3'd3; wb_value = 32'h55;
    #1;
`ifdef ROB_WB_BYPASS_EN
    exp_now = 1'b1;
`else
    exp_now = 1'b0;
`endif
    n_tests++; if (get_ready1 !== exp_now || (exp_now && get_value1 !== 32'h55)) begin n_fail++; $display("FAIL query_same got rdy=%0b val=%h exp rdy=%0b", get_ready1, get_value1, exp_now); end
    step(); wb_valid = 0;
    n_tests++; if (get_ready1 !== 1'b1 || get_value1 !== 32'h55) begin n_fail++; $display("FAIL query_next got rdy=%0b val=%h exp 1 55", get_ready1, get_value1); end
    rdy = 0; issue_valid = 1; issue_dest = 20; wb_valid = 1; wb_rob_id = 3'd0; wb_value = 32'h66;
    #1;
    n_tests++; if (issue_rd !== 5'd0) begin n_fail++; $display("FAIL stall_issue_rd got %0d exp 0", issue_rd); end
    step(); step();
    issue_valid = 0; wb_valid = 0; ask_rob_id2 = 3'd0;
    #1;
    n_tests++; if (issue_rob_id !== 3'd4 || get_ready2 !== 1'b0) begin n_fail++; $display("FAIL stall_state got id=%0d rdy2=%0b exp 4 0", issue_rob_id, get_ready2); end
    rdy = 1;
    wback(3'd0, 32'h66, 1'b0);
    step();
    n_tests++; if (commit_rd !== 5'd1 || commit_value !== 32'h66) begin n_fail++; $display("FAIL stall_commit got rd=%0d val=%h exp 1 66", commit_rd, commit_value); end
    rdy = 0;
    step(); step();
    n_tests++; if (commit_rd !== 5'd1 || commit_rob_id !== 3'd0) begin n_fail++; $display("FAIL stall_hold got rd=%0d id=%0d exp 1 0", commit_rd, commit_rob_id); end
    rdy = 1;
    step();
    n_tests++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL stall_release got rd=%0d exp 0", commit_rd); end
    $display("[TB] test_query_stall done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_out_of_order();
    test_flush();
    test_store();
    test_query_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
